// File: rtl/imm_pkg.sv
// ============================================================================
// Module : imm_pkg
// Brief  : Immediate extension mode encodings shared by the extender pipeline.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package imm_pkg;

  typedef logic [1:0] imm_mode_t;

  localparam imm_mode_t MODE_SEXT = 2'b00;
  localparam imm_mode_t MODE_ZEXT = 2'b01;
  localparam imm_mode_t MODE_LUI  = 2'b10;
  localparam imm_mode_t MODE_BOFS = 2'b11;

endpackage

`default_nettype wire

// File: rtl/imm_ext_fn.sv
// ============================================================================
// Module : imm_ext_fn
// Brief  : Combinational immediate extender (SEXT / ZEXT / LUI / branch offset).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imm_ext_fn
  import imm_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  imm_mode_t        mode,
  output logic [OUT_W-1:0] ext
);

  logic [OUT_W-1:0] sext;

  assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

  always_comb begin
    ext = sext;
    case (mode)
      MODE_SEXT: ext = sext;
      MODE_ZEXT: ext = {{(OUT_W-IN_W){1'b0}}, imm};
      MODE_LUI:  ext = {imm, {(OUT_W-IN_W){1'b0}}};
      // Word-aligned branch offset: the two MSBs of the sign extension fall off.
      MODE_BOFS: ext = {sext[OUT_W-3:0], 2'b00};
      default:   ext = sext;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/imm_extend_pipe.sv
// ============================================================================
// Module : imm_extend_pipe
// Brief  : Immediate extender with registered valid/ready output and skid entry.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  imm_mode_t        in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm
);

  logic [OUT_W-1:0] in_ext;
  logic [OUT_W-1:0] skid_data;
  logic             skid_valid;
  logic             ready_q;
  logic             in_fire;
  logic             out_free;

  imm_ext_fn #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_ext (
    .imm  (in_imm),
    .mode (in_mode),
    .ext  (in_ext)
  );

  // ready_q mirrors !skid_valid so in_ready never depends on out_ready.
  assign in_ready = ready_q;
  assign in_fire  = in_valid & ready_q;
  assign out_free = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_imm    <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      ready_q    <= 1'b1;
    end else if (out_free) begin
      if (skid_valid) begin
        out_imm    <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
        ready_q    <= 1'b1;
      end else if (in_fire) begin
        out_imm    <= in_ext;
        out_valid  <= 1'b1;
      end else begin
        out_valid  <= 1'b0;
      end
    end else if (in_fire) begin
      skid_data  <= in_ext;
      skid_valid <= 1'b1;
      ready_q    <= 1'b0;
    end
  end

endmodule

`default_nettype wire
